cache_fill_controller: RTL and testbench

- Sequencing stage wrapped around the 4-line fully associative tag comparator.
- Owns the tag, valid and data arrays and drives them to the comparator.
- Latches each request address and consumes the comparator's hit/hit_index result.
- Returns data on a hit, or fetches the line from memory on a miss and fills the LRU victim.
- Maintains true-LRU ordering across the 4 lines.

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_lru_tracker.sv | 59 +++++
 rtl/cache_fill_controller.sv | 182 ++++++++++++++++++
 tb/tb_cache_fill_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizing for the 4-line fully associative cache fill controller.
package cache_pkg;

    localparam int unsigned CACHE_SIZE = 4;
    localparam int unsigned IDX_WIDTH  = 2;
    localparam int unsigned AGE_WIDTH  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MEM    = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/cache_lru_tracker.sv
// True-LRU age tracker for the 4 cache lines plus victim selection.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   touch_en     mark touch_idx as most recently used this cycle
//   touch_idx    line being touched
//   valid        per-line valid bits, used to prefer empty lines as victims
//   victim_idx   combinational victim: lowest invalid line, else the oldest line
//   ages         registered per-line ages (0 = MRU, 3 = LRU)
module cache_lru_tracker
    import cache_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  touch_en,
    input  logic [IDX_WIDTH-1:0]                  touch_idx,
    input  logic [CACHE_SIZE-1:0]                 valid,
    output logic [IDX_WIDTH-1:0]                  victim_idx,
    output logic [CACHE_SIZE-1:0][AGE_WIDTH-1:0]  ages
);

    // Lines younger than the touched line age by one; the touched line becomes 0.
    // Only ages below the touched age increment, so the 2-bit ages never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CACHE_SIZE; i++) begin
                ages[i] <= AGE_WIDTH'(i);
            end
        end else if (touch_en) begin
            for (int i = 0; i < CACHE_SIZE; i++) begin
                if (IDX_WIDTH'(i) == touch_idx) begin
                    ages[i] <= '0;
                end else if (ages[i] < ages[touch_idx]) begin
                    ages[i] <= ages[i] + AGE_WIDTH'(1);
                end
            end
        end
    end

    // Victim: lowest-index invalid line, otherwise the line holding the maximum age.
    always_comb begin
        logic found;
        victim_idx = '0;
        found      = 1'b0;
        for (int i = 0; i < CACHE_SIZE; i++) begin
            if (!found && !valid[i]) begin
                victim_idx = IDX_WIDTH'(i);
                found      = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < CACHE_SIZE; i++) begin
                if (ages[i] == AGE_WIDTH'(CACHE_SIZE - 1)) begin
                    victim_idx = IDX_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: rtl/cache_fill_controller.sv
// Sequencing stage around an external 4-line fully associative tag comparator.
// Holds tag/valid/data arrays, latches each request, returns data on a hit or
// fetches from memory on a miss and fills the LRU victim.
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   req_valid/req_addr/req_ready   request handshake (accepted only in IDLE)
//   resp_valid/resp_ready          response handshake; resp_data/resp_hit held while stalled
//   lookup_addr, tag_out_*, valid_* drive the comparator
//   hit, hit_index                 comparator result, sampled in LOOKUP
//   mem_req/mem_addr               memory read, held until mem_ack
//   mem_ack/mem_data               single-cycle memory completion with fill data
module cache_fill_controller
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    output logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic [ADDR_WIDTH-1:0] tag_out_0,
    output logic [ADDR_WIDTH-1:0] tag_out_1,
    output logic [ADDR_WIDTH-1:0] tag_out_2,
    output logic [ADDR_WIDTH-1:0] tag_out_3,
    output logic                  valid_0,
    output logic                  valid_1,
    output logic                  valid_2,
    output logic                  valid_3,
    input  logic                  hit,
    input  logic [IDX_WIDTH-1:0]  hit_index,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_data
);

    state_e state_q;
    state_e state_d;

    logic latch_addr;
    logic take_hit;
    logic start_fill;
    logic do_fill;

    logic [CACHE_SIZE-1:0][ADDR_WIDTH-1:0] tag_q;
    logic [CACHE_SIZE-1:0][DATA_WIDTH-1:0] data_q;
    logic [CACHE_SIZE-1:0]                 valid_q;
    logic [IDX_WIDTH-1:0]                  victim_q;

    logic                                 touch_en;
    logic [IDX_WIDTH-1:0]                 touch_idx;
    logic [IDX_WIDTH-1:0]                 victim_idx;
    logic [CACHE_SIZE-1:0][AGE_WIDTH-1:0] lru_ages;
    logic [CACHE_SIZE-1:0]                age_seen;

    assign tag_out_0 = tag_q[0];
    assign tag_out_1 = tag_q[1];
    assign tag_out_2 = tag_q[2];
    assign tag_out_3 = tag_q[3];
    assign valid_0   = valid_q[0];
    assign valid_1   = valid_q[1];
    assign valid_2   = valid_q[2];
    assign valid_3   = valid_q[3];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; inputs are only looked at in their own state.
    always_comb begin
        state_d    = state_q;
        latch_addr = 1'b0;
        take_hit   = 1'b0;
        start_fill = 1'b0;
        do_fill    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    latch_addr = 1'b1;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    take_hit = 1'b1;
                    state_d  = RESP;
                end else begin
                    start_fill = 1'b1;
                    state_d    = MEM;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    do_fill = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs track the next state so they are valid in the same cycle as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            mem_req     <= 1'b0;
            lookup_addr <= '0;
            resp_data   <= '0;
            resp_hit    <= 1'b0;
            mem_addr    <= '0;
            victim_q    <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            valid_q     <= '0;
        end else begin
            req_ready  <= (state_d == IDLE);
            resp_valid <= (state_d == RESP);
            mem_req    <= (state_d == MEM);
            if (latch_addr) begin
                lookup_addr <= req_addr;
            end
            if (take_hit) begin
                resp_data <= data_q[hit_index];
                resp_hit  <= 1'b1;
            end
            // Victim is frozen at miss time so the fill lands where the LRU pointed then.
            if (start_fill) begin
                victim_q <= victim_idx;
                mem_addr <= lookup_addr;
            end
            if (do_fill) begin
                tag_q[victim_q]   <= lookup_addr;
                valid_q[victim_q] <= 1'b1;
                data_q[victim_q]  <= mem_data;
                resp_data         <= mem_data;
                resp_hit          <= 1'b0;
            end
        end
    end

    assign touch_en  = take_hit | do_fill;
    assign touch_idx = take_hit ? hit_index : victim_q;

    cache_lru_tracker u_lru (
        .clk        (clk),
        .rst        (rst),
        .touch_en   (touch_en),
        .touch_idx  (touch_idx),
        .valid      (valid_q),
        .victim_idx (victim_idx),
        .ages       (lru_ages)
    );

    // Ages must stay a permutation of 0..3.
    always_comb begin
        age_seen = '0;
        for (int i = 0; i < CACHE_SIZE; i++) begin
            age_seen[lru_ages[i]] = 1'b1;
        end
    end

    lru_perm_a: assert property (@(posedge clk) disable iff (rst) (&age_seen));

endmodule

// File: tb/tb_cache_fill_controller.sv
// Bench for cache_fill_controller: comparator and memory modelled here, results
// checked against a recency-list cache model.
module tb_cache_fill_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] resp_data;
    logic       resp_hit;
    logic [7:0] lookup_addr;
    logic [7:0] tag_out_0, tag_out_1, tag_out_2, tag_out_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic       hit;
    logic [1:0] hit_index;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_data = 8'h00;

    always #5 clk = ~clk;

    cache_fill_controller dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_hit    (resp_hit),
        .lookup_addr (lookup_addr),
        .tag_out_0   (tag_out_0),
        .tag_out_1   (tag_out_1),
        .tag_out_2   (tag_out_2),
        .tag_out_3   (tag_out_3),
        .valid_0     (valid_0),
        .valid_1     (valid_1),
        .valid_2     (valid_2),
        .valid_3     (valid_3),
        .hit         (hit),
        .hit_index   (hit_index),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
    );

    // Comparator model, with an override used to inject spurious hits.
    logic [7:0] dut_tag [4];
    logic       dut_val [4];
    logic       cmp_hit;
    logic [1:0] cmp_idx;
    logic       force_en = 1'b0;
    logic       force_hit = 1'b0;
    logic [1:0] force_idx = 2'd0;

    always_comb begin
        dut_tag[0] = tag_out_0; dut_tag[1] = tag_out_1;
        dut_tag[2] = tag_out_2; dut_tag[3] = tag_out_3;
        dut_val[0] = valid_0;   dut_val[1] = valid_1;
        dut_val[2] = valid_2;   dut_val[3] = valid_3;
        cmp_hit = 1'b0;
        cmp_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (dut_val[i] && dut_tag[i] == lookup_addr) begin
                cmp_hit = 1'b1;
                cmp_idx = 2'(i);
            end
        end
    end

    assign hit       = force_en ? force_hit : cmp_hit;
    assign hit_index = force_en ? force_idx : cmp_idx;

    // Reference model: line contents plus a recency list (front = most recent).
    logic [7:0] mem_img [256];
    logic [7:0] m_tag [4];
    logic       m_val [4];
    logic [7:0] m_dat [4];
    int         order [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tag[i] = 8'h00;
            m_val[i] = 1'b0;
            m_dat[i] = 8'h00;
        end
        order = {0, 1, 2, 3};
    endfunction

    function automatic int model_find(input logic [7:0] a);
        for (int i = 0; i < 4; i++) begin
            if (m_val[i] && m_tag[i] == a) return i;
        end
        return -1;
    endfunction

    function automatic int model_victim();
        for (int i = 0; i < 4; i++) begin
            if (!m_val[i]) return i;
        end
        return order[order.size() - 1];
    endfunction

    function automatic void model_touch(input int k);
        for (int j = 0; j < order.size(); j++) begin
            if (order[j] == k) begin
                order.delete(j);
                break;
            end
        end
        order.push_front(k);
    endfunction

    function automatic int age_of(input int line);
        for (int j = 0; j < order.size(); j++) begin
            if (order[j] == line) return j;
        end
        return -1;
    endfunction

    task automatic check_arrays(input string tg);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_valid%0d", tg, i), 32'(dut_val[i]), 32'(m_val[i]));
            chk($sformatf("%s_tag%0d", tg, i), 32'(dut_tag[i]), 32'(m_tag[i]));
            chk($sformatf("%s_age%0d", tg, i), 32'(dut.u_lru.ages[i]), 32'(age_of(i)));
        end
    endtask

    // One full request/response transaction with optional memory delay and response stall.
    task automatic do_req(input logic [7:0] addr, input int ack_dly, input int stall,
                          output logic got_hit);
        int         idx;
        int         line;
        logic       e_hit;
        logic [7:0] e_data;
        int         w;
        idx    = model_find(addr);
        e_hit  = (idx >= 0);
        line   = e_hit ? idx : model_victim();
        e_data = e_hit ? m_dat[idx] : mem_img[addr];

        w = 0;
        while (!req_ready && w < 20) begin
            step();
            w++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        chk("lookup_addr", 32'(lookup_addr), 32'(addr));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        chk("resp_early", 32'(resp_valid), 32'd0);
        chk("mem_req_early", 32'(mem_req), 32'd0);
        step();
        if (e_hit) begin
            chk("hit_no_mem_req", 32'(mem_req), 32'd0);
        end else begin
            chk("mem_req_rise", 32'(mem_req), 32'd1);
            chk("mem_addr", 32'(mem_addr), 32'(addr));
            for (int d = 0; d < ack_dly; d++) begin
                step();
                chk("mem_req_hold", 32'(mem_req), 32'd1);
                chk("mem_addr_hold", 32'(mem_addr), 32'(addr));
                chk("resp_during_mem", 32'(resp_valid), 32'd0);
            end
            mem_ack  = 1'b1;
            mem_data = mem_img[addr];
            step();
            mem_ack  = 1'b0;
            mem_data = 8'($urandom);
            chk("mem_req_drop", 32'(mem_req), 32'd0);
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_data", 32'(resp_data), 32'(e_data));
        chk("resp_hit", 32'(resp_hit), 32'(e_hit));
        got_hit = resp_hit;

        for (int s = 0; s < stall; s++) begin
            if (s == 0) begin
                req_valid = 1'b1;
                req_addr  = addr ^ 8'hFF;
            end
            step();
            req_valid = 1'b0;
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            chk("stall_resp_data", 32'(resp_data), 32'(e_data));
            chk("stall_resp_hit", 32'(resp_hit), 32'(e_hit));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("resp_done", 32'(resp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
        chk("lookup_kept", 32'(lookup_addr), 32'(addr));

        if (!e_hit) begin
            m_tag[line] = addr;
            m_val[line] = 1'b1;
            m_dat[line] = mem_img[addr];
        end
        model_touch(line);
        check_arrays("txn");
    endtask

    typedef struct {
        logic [7:0] addr;
        int         ack_dly;
        int         stall;
        logic       exp_hit;
        int         exp_line;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic       h;
        logic [7:0] a;
        logic [7:0] snap_look;

        for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
        mem_img[8'h10] = 8'hB5;
        model_reset();

        // Hand-derived fill / LRU eviction sequence.
        vecs[0] = '{addr: 8'h10, ack_dly: 2, stall: 0, exp_hit: 1'b0, exp_line: 0};
        vecs[1] = '{addr: 8'h10, ack_dly: 0, stall: 0, exp_hit: 1'b1, exp_line: 0};
        vecs[2] = '{addr: 8'h20, ack_dly: 1, stall: 0, exp_hit: 1'b0, exp_line: 1};
        vecs[3] = '{addr: 8'h30, ack_dly: 0, stall: 5, exp_hit: 1'b0, exp_line: 2};
        vecs[4] = '{addr: 8'h40, ack_dly: 3, stall: 0, exp_hit: 1'b0, exp_line: 3};
        vecs[5] = '{addr: 8'h10, ack_dly: 0, stall: 5, exp_hit: 1'b1, exp_line: 0};
        vecs[6] = '{addr: 8'h50, ack_dly: 1, stall: 0, exp_hit: 1'b0, exp_line: 1};
        vecs[7] = '{addr: 8'h20, ack_dly: 0, stall: 1, exp_hit: 1'b0, exp_line: 2};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_lookup", 32'(lookup_addr), 32'd0);
        check_arrays("rst");

        for (int v = 0; v < 8; v++) begin
            do_req(vecs[v].addr, vecs[v].ack_dly, vecs[v].stall, h);
            chk($sformatf("tbl%0d_hit", v), 32'(h), 32'(vecs[v].exp_hit));
            chk($sformatf("tbl%0d_tag", v), 32'(dut_tag[vecs[v].exp_line]), 32'(vecs[v].addr));
            chk($sformatf("tbl%0d_valid", v), 32'(dut_val[vecs[v].exp_line]), 32'd1);
        end

        // Spurious mem_ack and hit while idle change nothing.
        snap_look = lookup_addr;
        mem_ack   = 1'b1;
        mem_data  = 8'hEE;
        force_en  = 1'b1;
        force_hit = 1'b1;
        force_idx = 2'd2;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("spur_req_ready", 32'(req_ready), 32'd1);
            chk("spur_resp_valid", 32'(resp_valid), 32'd0);
            chk("spur_mem_req", 32'(mem_req), 32'd0);
            chk("spur_lookup", 32'(lookup_addr), 32'(snap_look));
        end
        mem_ack  = 1'b0;
        force_en = 1'b0;
        check_arrays("spur");

        // Randomised traffic over a small address pool to mix hits and evictions.
        for (int n = 0; n < 60; n++) begin
            a = 8'(16 * $urandom_range(1, 6));
            do_req(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), h);
        end

        // Reset while waiting on memory.
        a = 8'h77;
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        step();
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        model_reset();
        check_arrays("rst_mid");
        @(negedge clk);
        rst      = 1'b0;
        mem_ack  = 1'b1;
        mem_data = mem_img[a];
        step();
        mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("late_ack_resp", 32'(resp_valid), 32'd0);
            chk("late_ack_mem_req", 32'(mem_req), 32'd0);
            chk("late_ack_req_ready", 32'(req_ready), 32'd1);
            step();
        end
        check_arrays("late_ack");

        // Post-reset traffic still works.
        for (int n = 0; n < 10; n++) begin
            a = 8'(16 * $urandom_range(1, 6));
            do_req(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
